pipe_track: RTL and testbench



---
 rtl/pipe_track_pkg.sv | 32 +++
 rtl/pipe_track_if.sv | 48 ++++
 rtl/pipe_track_fwd_lookup.sv | 65 ++++++
 rtl/pipe_track.sv | 128 ++++++++++++
 tb/tb_pipe_track.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_track_pkg.sv
// pipe_track_pkg: shared types and defaults for the elastic pipeline tracker.
// The PIPE_TRACK_FWD_EN build option is consumed by pipe_track_fwd_lookup.
package pipe_track_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_RFADDR     = 5;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_NSRC       = 2;
  localparam int unsigned DEF_LATE_STAGE = 1;

  // One tracked stage at the default widths.
  typedef struct packed {
    logic                  valid;
    logic [DEF_RFADDR-1:0] rd;
    logic                  wr_en;
    logic [DEF_WIDTH-1:0]  data;
    logic                  rdy;
  } pipe_entry_t;

  // Result of one forwarding query.
  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_DATA,
    FWD_STALL
  } fwd_sel_t;

  // Width of a count that must be able to express 0..depth.
  function automatic int unsigned fd_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_track_if.sv
// pipe_track_if: producer, retire, late-insert, flush and forwarding-query
// signals of the pipeline tracker. The master drives stimulus; the slave is
// the tracker itself.
interface pipe_track_if
  import pipe_track_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned RFADDR = DEF_RFADDR,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NSRC   = DEF_NSRC
);
  localparam int unsigned FDW = fd_width(DEPTH);

  logic                        in_valid;
  logic                        in_ready;
  logic [RFADDR-1:0]           in_rd;
  logic                        in_wr_en;
  logic [WIDTH-1:0]            in_data;
  logic                        in_data_rdy;
  logic                        late_en;
  logic [WIDTH-1:0]            late_data;
  logic                        flush;
  logic [FDW-1:0]              flush_depth;
  logic                        out_valid;
  logic                        out_ready;
  logic [RFADDR-1:0]           out_rd;
  logic                        out_wr_en;
  logic [WIDTH-1:0]            out_data;
  logic [NSRC-1:0][RFADDR-1:0] src_addr;
  logic [NSRC-1:0]             fwd_hit;
  logic [NSRC-1:0][WIDTH-1:0]  fwd_data;
  logic [NSRC-1:0]             fwd_stall;

  modport master (
    output in_valid, in_rd, in_wr_en, in_data, in_data_rdy,
    output late_en, late_data, flush, flush_depth, out_ready, src_addr,
    input  in_ready, out_valid, out_rd, out_wr_en, out_data,
    input  fwd_hit, fwd_data, fwd_stall
  );

  modport slave (
    input  in_valid, in_rd, in_wr_en, in_data, in_data_rdy,
    input  late_en, late_data, flush, flush_depth, out_ready, src_addr,
    output in_ready, out_valid, out_rd, out_wr_en, out_data,
    output fwd_hit, fwd_data, fwd_stall
  );

endinterface

// File: rtl/pipe_track_fwd_lookup.sv
// pipe_track_fwd_lookup: combinational youngest-first register match over
// all tracked stages for one operand query port.
// PIPE_TRACK_FWD_EN defined: forward ready data, stall on unready data.
// PIPE_TRACK_FWD_EN undefined: interlock only, stall on any match.
module pipe_track_fwd_lookup
  import pipe_track_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned RFADDR = DEF_RFADDR,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0]             wr_en_i,
  input  logic [DEPTH-1:0]             rdy_i,
  input  logic [DEPTH-1:0][RFADDR-1:0] rd_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]  data_i,
  input  logic [RFADDR-1:0]            src_i,
  output logic                         hit_o,
  output logic                         stall_o,
  output logic [WIDTH-1:0]             data_o
);

  fwd_sel_t         sel;
  logic             found;
  logic             found_rdy;
  logic [WIDTH-1:0] found_data;

  // Scan oldest to youngest so the youngest matching stage is left selected.
  always_comb begin
    // NOTE: every variable gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    found      = 1'b0;
    found_rdy  = 1'b0;
    found_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_i[k] && wr_en_i[k] && (rd_i[k] == src_i) && (src_i != '0)) begin
        found      = 1'b1;
        found_rdy  = rdy_i[k];
        found_data = data_i[k];
      end
    end
  end

`ifdef PIPE_TRACK_FWD_EN
  // Full forwarding: ready data is bypassed, an unready producer interlocks.
  always_comb begin
    sel = FWD_NONE;
    if (found) sel = found_rdy ? FWD_DATA : FWD_STALL;
  end
  assign data_o = (sel == FWD_DATA) ? found_data : '0;
`else
  // Interlock only: any in-flight producer stalls the consumer.
  always_comb begin
    sel = FWD_NONE;
    if (found) sel = FWD_STALL;
  end
  assign data_o = '0;
  logic unused_fwd;
  assign unused_fwd = ^{found_rdy, found_data};
`endif

  assign hit_o   = (sel == FWD_DATA);
  assign stall_o = (sel == FWD_STALL);

endmodule

// File: rtl/pipe_track.sv
// pipe_track: DEPTH-stage elastic pipeline carrying destination metadata and
// results, with bubble collapse, partial flush of the youngest stages, late
// data insertion at LATE_STAGE and NSRC forwarding/interlock query ports.
// Forwarding vs interlock-only is selected by PIPE_TRACK_FWD_EN.
module pipe_track
  import pipe_track_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned RFADDR     = DEF_RFADDR,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned NSRC       = DEF_NSRC,
  parameter int unsigned LATE_STAGE = DEF_LATE_STAGE
) (
  input logic         clk,
  input logic         reset,
  pipe_track_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [RFADDR-1:0] rd;
    logic              wr_en;
    logic [WIDTH-1:0]  data;
    logic              rdy;
  } stage_t;

  stage_t             stage_q [DEPTH];
  stage_t             stage_d [DEPTH];
  stage_t             eff     [DEPTH];   // stage after flush and late insert
  logic [DEPTH-1:0]   move;
  logic               slot0_free;
  logic               accept;

  // Apply flush, then late insert, then resolve the advance chain from the
  // oldest stage back to the youngest.
  always_comb begin : pre_move
    logic adv;
    for (int k = 0; k < DEPTH; k++) begin
      eff[k] = stage_q[k];
      if (bus.flush && (k < int'(bus.flush_depth))) eff[k].valid = 1'b0;
    end
    if (bus.late_en && eff[LATE_STAGE].valid) begin
      eff[LATE_STAGE].data = bus.late_data;
      eff[LATE_STAGE].rdy  = 1'b1;
    end
    adv  = bus.out_ready;
    move = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      move[k] = eff[k].valid & adv;
      adv     = !eff[k].valid | move[k];
    end
    slot0_free = adv;
  end

  assign bus.in_ready = !reset && !bus.flush && slot0_free;
  assign accept       = bus.in_valid && bus.in_ready;

  // Next state: hold entries that cannot move, pull in the entry behind.
  always_comb begin : next_state
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k]       = eff[k];
      stage_d[k].valid = eff[k].valid & !move[k];
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (move[k-1]) stage_d[k] = eff[k-1];
    end
    if (accept) begin
      stage_d[0].valid = 1'b1;
      stage_d[0].rd    = bus.in_rd;
      stage_d[0].wr_en = bus.in_wr_en;
      stage_d[0].data  = bus.in_data;
      stage_d[0].rdy   = bus.in_data_rdy;
    end
  end

  // Stage registers with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: the stages are a handful of flops, not a RAM, so clearing every
    // field on reset costs nothing and keeps the retire fields at zero.
    // Sequential state is always written with non-blocking assignments.
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign bus.out_valid = stage_q[DEPTH-1].valid;
  assign bus.out_rd    = stage_q[DEPTH-1].rd;
  assign bus.out_wr_en = stage_q[DEPTH-1].wr_en;
  assign bus.out_data  = stage_q[DEPTH-1].data;

  logic [DEPTH-1:0]             v_vec;
  logic [DEPTH-1:0]             w_vec;
  logic [DEPTH-1:0]             r_vec;
  logic [DEPTH-1:0][RFADDR-1:0] rd_vec;
  logic [DEPTH-1:0][WIDTH-1:0]  data_vec;

  // Flatten the registered stages for the lookup ports.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      v_vec[k]    = stage_q[k].valid;
      w_vec[k]    = stage_q[k].wr_en;
      r_vec[k]    = stage_q[k].rdy;
      rd_vec[k]   = stage_q[k].rd;
      data_vec[k] = stage_q[k].data;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_lookup
    pipe_track_fwd_lookup #(
      .WIDTH  (WIDTH),
      .RFADDR (RFADDR),
      .DEPTH  (DEPTH)
    ) u_lookup (
      .valid_i (v_vec),
      .wr_en_i (w_vec),
      .rdy_i   (r_vec),
      .rd_i    (rd_vec),
      .data_i  (data_vec),
      .src_i   (bus.src_addr[i]),
      .hit_o   (bus.fwd_hit[i]),
      .stall_o (bus.fwd_stall[i]),
      .data_o  (bus.fwd_data[i])
    );
  end

endmodule

// File: tb/tb_pipe_track.sv
// tb_pipe_track: directed bench for pipe_track with a retire scoreboard.
// Expectations follow PIPE_TRACK_FWD_EN as compiled.
module tb_pipe_track;
  import pipe_track_pkg::*;

`ifdef PIPE_TRACK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  pipe_track_if #(.WIDTH(32), .RFADDR(5), .DEPTH(4), .NSRC(2)) bus ();

  pipe_track #(
    .WIDTH(32), .RFADDR(5), .DEPTH(4), .NSRC(2), .LATE_STAGE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_ret = 0;
  int          ret0;
  logic [31:0] exp_data;
  pipe_entry_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Retire/accept bookkeeping just before the edge, then advance one cycle.
  task automatic step();
    pipe_entry_t e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("retire_unexpected", bus.out_valid, 0);
      end else begin
        e = sb_q.pop_front();
        chk("out_rd", bus.out_rd, e.rd);
        chk("out_wr_en", bus.out_wr_en, e.wr_en);
        chk("out_data", bus.out_data, e.data);
        n_ret++;
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e       = '0;
      e.valid = 1'b1;
      e.rd    = bus.in_rd;
      e.wr_en = bus.in_wr_en;
      e.data  = exp_data;
      e.rdy   = bus.in_data_rdy;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] data,
                       input logic rdy, input logic [31:0] xdata);
    bus.in_valid    = 1'b1;
    bus.in_rd       = rd;
    bus.in_wr_en    = 1'b1;
    bus.in_data     = data;
    bus.in_data_rdy = rdy;
    exp_data        = xdata;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_rd       = '0;
    bus.in_wr_en    = 1'b0;
    bus.in_data     = '0;
    bus.in_data_rdy = 1'b0;
    bus.late_en     = 1'b0;
    bus.late_data   = '0;
    bus.flush       = 1'b0;
    bus.flush_depth = '0;
    bus.out_ready   = 1'b0;
    bus.src_addr    = '0;
    exp_data        = '0;

    // Reset: nothing accepted while reset is held.
    @(posedge clk); #1;
    offer(5'd5, 32'h55, 1'b1, 32'h55);
    #1;
    chk("in_ready_in_reset", bus.in_ready, 0);
    step();
    idle();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_out_wr_en", bus.out_wr_en, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_fwd_hit", bus.fwd_hit, 0);
    chk("rst_fwd_stall", bus.fwd_stall, 0);
    chk("rst_fwd_data", bus.fwd_data, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Streaming: 4-cycle latency, one entry per cycle, in order.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(5'd5, 32'h11 + i, 1'b1, 32'h11 + i);
      #1;
      chk("t1_out_valid", bus.out_valid, (i >= 4));
      chk("t1_in_ready", bus.in_ready, 1);
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();
    chk("t1_drained", sb_q.size(), 0);
    chk("t1_ret_count", n_ret, 8);

    // Back-pressure: fills four stages then refuses.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer(5'd6, 32'h100 + i, 1'b1, 32'h100 + i);
      #1;
      chk("t2_in_ready", bus.in_ready, (i < 4));
      step();
    end
    idle();
    chk("t2_full_out_valid", bus.out_valid, 1);
    ret0 = n_ret;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("t2_ret_count", n_ret - ret0, 4);
    chk("t2_drained", sb_q.size(), 0);

    // Load with late data inserted at stage 1.
    bus.out_ready = 1'b0;
    bus.src_addr[0] = 5'd7;
    bus.src_addr[1] = 5'd0;
    offer(5'd7, 32'h0, 1'b0, 32'hDEAD);
    step();
    idle();
    #1;
    chk("t3_stall_s0", bus.fwd_stall[0], 1);
    chk("t3_hit_s0", bus.fwd_hit[0], 0);
    step();
    bus.late_en   = 1'b1;
    bus.late_data = 32'hDEAD;
    #1;
    chk("t3_stall_s1", bus.fwd_stall[0], 1);
    step();
    bus.late_en = 1'b0;
    #1;
    chk("t3_hit_late", bus.fwd_hit[0], FWD);
    chk("t3_data_late", bus.fwd_data[0], FWD ? 32'hDEAD : 32'h0);
    chk("t3_stall_late", bus.fwd_stall[0], !FWD);
    chk("t3_p1_zero_hit", bus.fwd_hit[1], 0);
    chk("t3_p1_zero_stall", bus.fwd_stall[1], 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t3_drained", sb_q.size(), 0);

    // Youngest match wins; then a partial flush of stages 0 and 1.
    bus.out_ready = 1'b0;
    offer(5'd3, 32'hB, 1'b1, 32'hB);
    step();
    offer(5'd4, 32'h44, 1'b1, 32'h44);
    step();
    offer(5'd3, 32'hA, 1'b1, 32'hA);
    step();
    offer(5'd8, 32'hC, 1'b1, 32'hC);
    bus.src_addr[0] = 5'd3;
    bus.src_addr[1] = 5'd0;
    #1;
    chk("t4_hit_young", bus.fwd_hit[0], FWD);
    chk("t4_data_young", bus.fwd_data[0], FWD ? 32'hA : 32'h0);
    chk("t4_stall_young", bus.fwd_stall[0], !FWD);
    chk("t4_r0_hit", bus.fwd_hit[1], 0);
    chk("t4_r0_stall", bus.fwd_stall[1], 0);
    chk("t4_r0_data", bus.fwd_data[1], 0);
    bus.src_addr[1] = 5'd4;
    #1;
    chk("t4_p1_hit", bus.fwd_hit[1], FWD);
    chk("t4_p1_data", bus.fwd_data[1], FWD ? 32'h44 : 32'h0);
    chk("t4_in_ready", bus.in_ready, 1);
    step();
    offer(5'd9, 32'hD, 1'b1, 32'hD);
    bus.flush       = 1'b1;
    bus.flush_depth = 3'd2;
    #1;
    chk("t5_in_ready_flush", bus.in_ready, 0);
    step();
    bus.flush = 1'b0;
    idle();
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    ret0 = n_ret;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t5_ret_count", n_ret - ret0, 2);
    chk("t5_drained", sb_q.size(), 0);

    // Ready entry rd=9; flush_depth=0 is a no-op; flush_depth>=DEPTH empties.
    bus.out_ready = 1'b0;
    bus.src_addr[0] = 5'd9;
    offer(5'd9, 32'h99, 1'b1, 32'h99);
    step();
    idle();
    bus.flush       = 1'b1;
    bus.flush_depth = 3'd0;
    step();
    bus.flush = 1'b0;
    #1;
    chk("t6_stall_rdy", bus.fwd_stall[0], !FWD);
    chk("t6_hit_rdy", bus.fwd_hit[0], FWD);
    chk("t6_data_rdy", bus.fwd_data[0], FWD ? 32'h99 : 32'h0);
    offer(5'd10, 32'hAA, 1'b1, 32'hAA);
    step();
    idle();
    bus.flush       = 1'b1;
    bus.flush_depth = 3'd7;
    step();
    bus.flush = 1'b0;
    sb_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t6_all_flushed", bus.out_valid, 0);
    chk("t6_no_stall", bus.fwd_stall[0], 0);

    // Reset in mid-operation discards everything.
    bus.out_ready = 1'b0;
    offer(5'd11, 32'h1111, 1'b1, 32'h1111);
    step();
    offer(5'd12, 32'h2222, 1'b1, 32'h2222);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("t7_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t7_empty", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
